// File: rtl/game.sv
// Conway's Game of Life on an 8x8 board with dead borders (no wrap-around).
// grid_evolve is the state register itself; reset loads the seed, en advances one generation.
module game (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [63:0] grid,
    output logic [63:0] grid_evolve
);

    logic [63:0] next_gen;

    // Live neighbours of cell (r, c); positions off the board contribute nothing.
    function automatic logic [3:0] neighbours(input logic [63:0] s, input int r, input int c);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) &&
                    (r + dr >= 0) && (r + dr <= 7) &&
                    (c + dc >= 0) && (c + dc <= 7)) begin
                    cnt = cnt + {3'b000, s[63 - 8*(r + dr) - (c + dc)]};
                end
            end
        end
        return cnt;
    endfunction

    // Every cell reads only grid_evolve, so all 64 cells update together.
    always_comb begin
        // NOTE: default assignment first so no path through this block leaves next_gen unassigned (no latch).
        next_gen = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                logic [3:0] n;
                n = neighbours(grid_evolve, r, c);
                next_gen[63 - 8*r - c] = (n == 4'd3) || (grid_evolve[63 - 8*r - c] && n == 4'd2);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for state; blocking here would race with other clocked readers.
        if (!reset) begin
            grid_evolve <= grid;
        end else if (en) begin
            grid_evolve <= next_gen;
        end
    end

endmodule

// File: tb/tb_game.sv
// Randomised and directed bench for game: a padded-board life model feeds a scoreboard queue
// that an independent monitor drains one entry per cycle.
module tb_game;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [63:0] grid;
    logic [63:0] grid_evolve;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];
    logic [63:0] model;
    bit          stim_done = 1'b0;

    localparam logic [63:0] BLINK_H = 64'h0070_0000_0000_0000;
    localparam logic [63:0] BLINK_V = 64'h2020_2000_0000_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] CORNER  = 64'hC080_0000_0000_0000;
    localparam logic [63:0] TOPROW  = 64'hE000_0000_0000_0000;
    localparam logic [63:0] SINGLE  = 64'h0000_0010_0000_0000;

    game dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .grid        (grid),
        .grid_evolve (grid_evolve)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference generation: copy the board into a 10x10 array with a dead frame, then apply the rules.
    function automatic logic [63:0] life_next(input logic [63:0] s);
        int b[10][10];
        logic [63:0] res;
        int n;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                b[i][j] = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r+1][c+1] = s[63 - 8*r - c] ? 1 : 0;
        res = '0;
        for (int r = 1; r <= 8; r++) begin
            for (int c = 1; c <= 8; c++) begin
                n = b[r-1][c-1] + b[r-1][c] + b[r-1][c+1] + b[r][c-1] + b[r][c+1]
                  + b[r+1][c-1] + b[r+1][c] + b[r+1][c+1];
                res[63 - 8*(r-1) - (c-1)] = (n == 3) || (b[r][c] == 1 && n == 2);
            end
        end
        return res;
    endfunction

    // One clock of stimulus; the expected post-edge value is queued (a spec constant when given).
    task automatic step(input logic r, input logic e, input logic [63:0] g, input string name,
                        input bit use_exp = 1'b0, input logic [63:0] exp_val = '0);
        @(negedge clk);
        reset = r;
        en    = e;
        grid  = g;
        @(posedge clk);
        if (!r)     model = g;
        else if (e) model = life_next(model);
        exp_q.push_back(use_exp ? exp_val : model);
        name_q.push_back(name);
    endtask

    // Monitor: the output is valid every cycle after the first reset edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [63:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, grid_evolve, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        grid  = '0;
        model = '0;

        // Blinker, with en held during reset and grid noise while running.
        step(1'b0, 1'b1, BLINK_H, "reset_load_blinker", 1'b1, BLINK_H);
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "blinker_gen1", 1'b1, BLINK_V);
        step(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, "blinker_gen2", 1'b1, BLINK_H);

        step(1'b0, 1'b0, BLOCK, "reset_load_block", 1'b1, BLOCK);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, '0, "block_still", 1'b1, BLOCK);

        step(1'b0, 1'b0, CORNER, "reset_load_corner", 1'b1, CORNER);
        step(1'b1, 1'b1, '0, "corner_birth", 1'b1, 64'hC0C0_0000_0000_0000);

        step(1'b0, 1'b0, TOPROW, "reset_load_toprow", 1'b1, TOPROW);
        step(1'b1, 1'b1, '0, "toprow_no_wrap", 1'b1, 64'h4040_0000_0000_0000);

        step(1'b0, 1'b0, SINGLE, "reset_load_single", 1'b1, SINGLE);
        step(1'b1, 1'b1, '0, "single_dies", 1'b1, 64'h0);
        step(1'b1, 1'b1, '0, "empty_stays", 1'b1, 64'h0);
        step(1'b1, 1'b1, '0, "empty_stays", 1'b1, 64'h0);

        // Hold with en=0, then reset mid-run while en=1.
        step(1'b0, 1'b0, BLINK_H, "reset_load_blinker2", 1'b1, BLINK_H);
        step(1'b1, 1'b1, '0, "blinker2_gen1", 1'b1, BLINK_V);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, "hold_frozen", 1'b1, BLINK_V);
        step(1'b0, 1'b1, BLOCK, "midrun_reset", 1'b1, BLOCK);

        // Random soup: occasional reloads, mostly enabled cycles.
        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic        e;
            logic [63:0] g;
            r = ($urandom_range(0, 15) != 0);
            e = ($urandom_range(0, 3) != 0);
            g = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) g = g & {$urandom, $urandom};
            step(r, e, g, "random");
        end

        @(negedge clk);
        @(negedge clk);
        stim_done = 1'b1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game.md
GAME -- requirements
Module: game

Interface
REQ-001: Port `clk`, input, 1 bit; the single clock; all state updates on the rising edge.
REQ-002: Port `reset`, input, 1 bit; synchronous, active-low reset; sampled on the rising edge of `clk`.
REQ-003: Port `en`, input, 1 bit; generation-advance enable, active-high.
REQ-004: Port `grid`, input, 64 bits; seed pattern, loaded into the state register while reset is asserted.
REQ-005: Port `grid_evolve`, output, 64 bits; current generation, driven directly from the internal 64-bit state register.
REQ-006: Board geometry SHALL be 8x8, row r (0=top) and column c (0=left) at bit index 63-8r-c.
- Row 0 = bits [63:56], row 7 = bits [7:0].
- The MSB of each byte is the leftmost column.
- 1 = live, 0 = dead.

Function
REQ-007: The block SHALL hold one 64-bit state register; `grid_evolve` SHALL equal this register at all times, with no combinational path from `grid` or `en`.
REQ-008: On a rising edge with `reset`=0, the state SHALL load `grid`, regardless of `en`.
REQ-009: On a rising edge with `reset`=1 and `en`=1, the state SHALL be replaced by the next Conway generation of the current state; one generation per enabled cycle; latency 1 cycle.
REQ-010: On a rising edge with `reset`=1 and `en`=0, the state SHALL hold its value.
REQ-011: Neighbour count for each cell SHALL be the number of live cells among its 8 adjacent positions; count range 0..8, at least 4-bit arithmetic.
REQ-012: Cells outside the 8x8 board SHALL count as dead; there SHALL be no wrap-around at edges or corners.
REQ-013: Next-state rule SHALL be:
- A live cell with 2 or 3 live neighbours stays live.
- A dead cell with exactly 3 live neighbours becomes live.
- All other cells become or stay dead.
REQ-014: All 64 next-state values SHALL be computed in parallel from the same current state, never from partially updated values.
REQ-015: `grid` changes while `reset`=1 SHALL have no effect on the state.
REQ-016: Reset asserted mid-evolution SHALL discard the current generation and reload `grid` on that edge.

Reset
REQ-017: Reset value of `grid_evolve` SHALL be the value of `grid` sampled on the reset edge; there is no other reset state.
REQ-018: Reset SHALL take priority over `en`; power-up contents before the first reset edge are undefined.

Verification
REQ-019: Reset with `grid`=64'h0070_0000_0000_0000, then `en`=1 for 1 cycle -> 64'h2020_2000_0000_0000; 1 more cycle -> 64'h0070_0000_0000_0000 (blinker, period 2).
REQ-020: Reset with `grid`=64'h0000_0018_1800_0000, then `en`=1 for 5 cycles -> the output stays 64'h0000_0018_1800_0000 on every cycle (block still life).
REQ-021: Reset with `grid`=64'hC080_0000_0000_0000, then 1 enabled cycle -> 64'hC0C0_0000_0000_0000 (corner birth, no wrap).
REQ-022: Reset with `grid`=64'hE000_0000_0000_0000, then 1 enabled cycle -> 64'h4040_0000_0000_0000; row 7 stays 0, proving no vertical wrap.
REQ-023: Reset with `grid`=64'h0000_0010_0000_0000, then 1 enabled cycle -> 64'h0; further cycles -> the output remains 0.
REQ-024: Hold and mid-run reset:
- Blinker running, `en`=0 for 3 cycles -> the output is frozen.
- Then `reset`=0 with `grid`=64'h0000_0018_1800_0000 while `en`=1 -> the output equals 64'h0000_0018_1800_0000 after that edge.
